// File: rtl/conv2d_pointwise_nch.sv
// Pointwise (1x1) convolution across CH channels: pipelined multiply, adder tree, bias, ReLU.
// Optional build macro CONV2D_PW_SATURATE_EN selects a clamp instead of wrap-around on the output.
module conv2d_pointwise_nch #(
   parameter int IMG_Width  = 3,
   parameter int IMG_Height = 3,
   parameter int CH         = 12,
   parameter int Datawidth  = 32,
   parameter int FRAC       = 0,
   parameter int ReLU       = 1,
   parameter logic [CH*Datawidth-1:0]    WEIGHTS = {CH{Datawidth'(1)}},
   parameter logic signed [Datawidth-1:0] BIAS   = Datawidth'(1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CH*Datawidth-1:0]   In,
   input  logic                      valid_in,
   output logic                      ready_in,
   output logic [Datawidth-1:0]      Out,
   output logic                      valid_out,
   input  logic                      ready_out,
   output logic                      frame_last
);

   localparam int L    = (CH > 1) ? $clog2(CH) : 1;
   localparam int ACCW = Datawidth + $clog2(CH) + 1;
   localparam int PW   = (2*Datawidth > ACCW) ? 2*Datawidth : ACCW;
   localparam int SW   = ACCW + 1;
   localparam int NPIX = IMG_Width * IMG_Height;
   localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);
   localparam logic signed [SW-1:0] S_MAX = SW'({1'b0, {(Datawidth-1){1'b1}}});
   localparam logic signed [SW-1:0] S_MIN = ~S_MAX;

   // Operand count feeding tree level l (level 0 = the CH products).
   function automatic int lvl_cnt(input int l);
      int n;
      n = CH;
      for (int i = 0; i < l; i++) n = (n + 1) / 2;
      return n;
   endfunction

   function automatic logic signed [ACCW-1:0] pmul(
      input logic signed [Datawidth-1:0] a,
      input logic signed [Datawidth-1:0] b
   );
      logic signed [PW-1:0] p;
      p = (PW'(a) * PW'(b)) >>> FRAC;
      return p[ACCW-1:0];
   endfunction

   // Bias is added one bit wider than the tree so the sum itself never wraps.
   function automatic logic [Datawidth-1:0] stage_o(input logic signed [ACCW-1:0] t);
      logic signed [SW-1:0] s;
      s = SW'(t) + SW'(BIAS);
      if (ReLU != 0 && s < 0) s = '0;
`ifdef CONV2D_PW_SATURATE_EN
      if (s > S_MAX)      s = S_MAX;
      else if (s < S_MIN) s = S_MIN;
`endif
      return s[Datawidth-1:0];
   endfunction

   logic signed [ACCW-1:0] tree_q [0:L][0:CH];
   logic signed [ACCW-1:0] tree_d [0:L][0:CH];
   logic [L:0]             vld_q, vld_d;
   logic [Datawidth-1:0]   out_q, out_d;
   logic                   valid_out_q, valid_out_d;
   logic                   frame_last_q, frame_last_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   en;

   assign en         = !valid_out_q || ready_out;
   assign ready_in   = en;
   assign Out        = out_q;
   assign valid_out  = valid_out_q;
   assign frame_last = frame_last_q;

   // Level 0 holds the products; levels 1..L are the registered adder tree.
   always_comb begin
      tree_d = tree_q;
      vld_d  = vld_q;
      if (en) begin
         vld_d[0] = valid_in;
         for (int l = 1; l <= L; l++) vld_d[l] = vld_q[l-1];
         for (int k = 0; k <= CH; k++) tree_d[0][k] = '0;
         for (int k = 0; k < CH; k++)
            tree_d[0][k] = pmul(In[k*Datawidth +: Datawidth], WEIGHTS[k*Datawidth +: Datawidth]);
         for (int l = 1; l <= L; l++) begin
            for (int j = 0; j <= CH; j++) tree_d[l][j] = '0;
            for (int j = 0; j < (CH + 1) / 2; j++) begin
               if (2*j + 1 < lvl_cnt(l-1))
                  tree_d[l][j] = tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
               else if (2*j < lvl_cnt(l-1))
                  tree_d[l][j] = tree_q[l-1][2*j];
            end
         end
      end
   end

   // The pixel index of a newly loaded result already accounts for a drain in the same cycle.
   always_comb begin
      out_d        = out_q;
      valid_out_d  = valid_out_q;
      frame_last_d = frame_last_q;
      cnt_d        = cnt_q;
      if (valid_out_q && ready_out)
         cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
      if (en) begin
         valid_out_d  = vld_q[L];
         frame_last_d = vld_q[L] && (cnt_d == LAST_IDX);
         if (vld_q[L]) out_d = stage_o(tree_q[L][0]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tree_q       <= '{default: '0};
         vld_q        <= '0;
         out_q        <= '0;
         valid_out_q  <= 1'b0;
         frame_last_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         tree_q       <= tree_d;
         vld_q        <= vld_d;
         out_q        <= out_d;
         valid_out_q  <= valid_out_d;
         frame_last_q <= frame_last_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_conv2d_pointwise_nch.sv
// Directed bench for conv2d_pointwise_nch: CH=12, 16-bit, weights k+1, bias 1, 3x3 frame.
// A ReLU=1 and a ReLU=0 instance share the same stimulus.
module tb_conv2d_pointwise_nch;

   localparam int CH = 12;
   localparam int DW = 16;
   localparam logic [CH*DW-1:0] W_TB = {16'd12, 16'd11, 16'd10, 16'd9, 16'd8, 16'd7,
                                        16'd6,  16'd5,  16'd4,  16'd3, 16'd2, 16'd1};

   logic              clk = 1'b0;
   logic              rst;
   logic [CH*DW-1:0]  in_bus;
   logic              valid_in;
   logic              ready_out;
   logic              ready_in_r, ready_in_n;
   logic [DW-1:0]     out_r, out_n;
   logic              valid_out_r, valid_out_n;
   logic              frame_last_r, frame_last_n;

   int checks = 0;
   int errors = 0;
   int out_cnt = 0;

   always #5 clk = ~clk;

   conv2d_pointwise_nch #(
      .IMG_Width(3), .IMG_Height(3), .CH(CH), .Datawidth(DW), .FRAC(0), .ReLU(1),
      .WEIGHTS(W_TB), .BIAS(16'sd1)
   ) u_dut (
      .clk(clk), .rst(rst), .In(in_bus), .valid_in(valid_in), .ready_in(ready_in_r),
      .Out(out_r), .valid_out(valid_out_r), .ready_out(ready_out), .frame_last(frame_last_r)
   );

   conv2d_pointwise_nch #(
      .IMG_Width(3), .IMG_Height(3), .CH(CH), .Datawidth(DW), .FRAC(0), .ReLU(0),
      .WEIGHTS(W_TB), .BIAS(16'sd1)
   ) u_dut_nr (
      .clk(clk), .rst(rst), .In(in_bus), .valid_in(valid_in), .ready_in(ready_in_n),
      .Out(out_n), .valid_out(valid_out_n), .ready_out(ready_out), .frame_last(frame_last_n)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_all(input int v);
      for (int k = 0; k < CH; k++) in_bus[k*DW +: DW] = v[DW-1:0];
   endtask

   task automatic do_reset(input bit chk);
      @(posedge clk); #1;
      rst = 1'b1;
      valid_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      out_cnt = 0;
      #1;
      if (chk) begin
         check("rst_out", out_r, 0);
         check("rst_valid_out", valid_out_r, 0);
         check("rst_frame_last", frame_last_r, 0);
         check("rst_ready_in", ready_in_r, 1);
      end
   endtask

   // One pixel through an empty pipeline: latency, result of both builds, single-cycle valid.
   task automatic single(input string tag, input int v, input int exp_r, input int exp_n);
      int lat;
      @(posedge clk); #1;
      ready_out = 1'b1;
      set_all(v);
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out_r && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, 6);
      check({tag, "_out_relu"}, out_r, exp_r);
      check({tag, "_valid_norelu"}, valid_out_n, 1);
      check({tag, "_out_norelu"}, out_n, exp_n);
      check({tag, "_frame_last"}, frame_last_r, (out_cnt % 9 == 8) ? 1 : 0);
      out_cnt++;
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, valid_out_r, 0);
   endtask

   // Stream pixels In_k = first+i; expected Out = 78*(first+i)+1 in order, with an optional stall.
   task automatic stream(input string tag, input int n, input int first,
                         input int stall_start, input int stall_len);
      int sent, got, cyc;
      bit prev_stall;
      logic [DW-1:0] prev_out;
      logic prev_fl;
      sent = 0; got = 0; cyc = 0;
      prev_stall = 1'b0; prev_out = '0; prev_fl = 1'b0;
      while (got < n && cyc < 300) begin
         @(posedge clk); #1;
         ready_out = !(cyc >= stall_start && cyc < stall_start + stall_len);
         if (sent < n) begin
            valid_in = 1'b1;
            set_all(first + sent);
         end else begin
            valid_in = 1'b0;
         end
         #1;
         if (valid_out_r && !ready_out) check({tag, "_stall_ready_in"}, ready_in_r, 0);
         if (prev_stall) begin
            check({tag, "_stall_out_hold"}, out_r, prev_out);
            check({tag, "_stall_fl_hold"}, frame_last_r, prev_fl);
         end
         if (valid_out_r && ready_out) begin
            check({tag, "_out"}, out_r, 78 * (first + got) + 1);
            check({tag, "_out_norelu"}, out_n, 78 * (first + got) + 1);
            check({tag, "_frame_last"}, frame_last_r, (out_cnt % 9 == 8) ? 1 : 0);
            got++;
            out_cnt++;
         end
         prev_stall = valid_out_r && !ready_out;
         prev_out = out_r;
         prev_fl = frame_last_r;
         if (valid_in && ready_in_r) sent++;
         cyc++;
      end
      valid_in = 1'b0;
      ready_out = 1'b1;
      check({tag, "_count"}, got, n);
      @(posedge clk); #1;
      check({tag, "_drained"}, valid_out_r, 0);
   endtask

   initial begin
      int big;
      rst = 1'b1;
      valid_in = 1'b0;
      ready_out = 1'b1;
      in_bus = '0;

      do_reset(1'b1);

      // sum(1..12)=78, +1
      single("single_ones", 1, 79, 79);

      do_reset(1'b0);
      stream("frame10", 10, 0, -1, 0);

      // -2*78+1 = -155 -> ReLU 0, raw 0xFF65
      single("neg_two", -2, 0, 16'hFF65);

      do_reset(1'b0);
      stream("stall", 9, 0, 8, 10);

      big = 78 * 32767 + 1;
`ifdef CONV2D_PW_SATURATE_EN
      single("max_in", 32767, 16'h7FFF, 16'h7FFF);
      single("neg_sat", -4096, 0, 16'h8000);
`else
      single("max_in", 32767, big & 16'hFFFF, big & 16'hFFFF);
      // -4096*78+1 = -319487 -> low 16 bits 0x2001
      single("neg_sat", -4096, 0, 16'h2001);
`endif

      do_reset(1'b0);
      stream("pre_rst", 4, 0, -1, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         set_all(20 + i);
         valid_in = 1'b1;
      end
      do_reset(1'b1);
      stream("post_rst", 9, 0, -1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
